edit_cursor_ctrl: RTL and testbench



---
 rtl/edit_pkg.sv | 35 +++
 rtl/blink_gen.sv | 29 ++
 rtl/edit_cursor_ctrl.sv | 111 +++++++++++
 tb/tb_edit_cursor_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/edit_pkg.sv
// Shared edit-mode encodings and field indices.
// Used by the cursor controller, blinker and display mux.
package edit_pkg;

  typedef enum logic [1:0] {
    MODE_RUN        = 2'b00,
    MODE_ALARM_VIEW = 2'b01,
    MODE_SET_TIME   = 2'b10,
    MODE_SET_ALARM  = 2'b11
  } mode_e;

  localparam logic [1:0] FIELD_FIRST = 2'd0;
  localparam int TF_LAST = 2;
  localparam int AF_LAST = 3;

  function automatic mode_e next_mode(
    input mode_e m
  );
    case (m)
      MODE_RUN:        return MODE_ALARM_VIEW;
      MODE_ALARM_VIEW: return MODE_SET_TIME;
      MODE_SET_TIME:   return MODE_SET_ALARM;
      default:         return MODE_RUN;
    endcase
  endfunction

  function automatic logic [1:0] next_field(
    input logic [1:0] cur,
    input logic [1:0] last
  );
    return (cur == last) ? FIELD_FIRST
                         : cur + 2'd1;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Half-period blink generator with sync restart.
// Ports: clk, rst, restart -> blink (1 = visible).
module blink_gen #(
  parameter int HALF = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink
);

  localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt   <= '0;
      blink <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/edit_cursor_ctrl.sv
// Alarm-clock edit controller: mode, cursors, blink, inc strobes.
// Ports: clk, rst, btn_mode/next/inc -> S, CW, CW1, BLINK, inc_*.
module edit_cursor_ctrl
  import edit_pkg::*;
#(
  parameter int CLK_HZ     = 1000,
  parameter int BLINK_HALF = CLK_HZ / 4,
  parameter int TIMEOUT    = CLK_HZ * 10,
  parameter int CW_MAX     = AF_LAST,
  parameter int CW1_MAX    = TF_LAST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [1:0] S,
  output logic [1:0] CW,
  output logic [1:0] CW1,
  output logic       BLINK,
  output logic       inc_time,
  output logic       inc_alarm
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [1:0] CW_LAST  = 2'(CW_MAX);
  localparam logic [1:0] CW1_LAST = 2'(CW1_MAX);

  mode_e          s_q, s_d;
  logic [1:0]     cw_d, cw1_d;
  logic [IW-1:0]  idle_q, idle_d;
  logic           inc_t_d, inc_a_d;
  logic           set_mode, do_next, do_inc;
  logic           restart, timeout, tick;

  assign S = s_q;

  always_comb begin
    set_mode = (s_q == MODE_SET_TIME) ||
               (s_q == MODE_SET_ALARM);
    do_next  = set_mode & ~btn_mode & btn_next;
    do_inc   = set_mode & ~btn_mode & ~btn_next
             & btn_inc;
    restart  = btn_mode | do_next | do_inc;
    // a press on the timeout cycle cancels it
    timeout  = set_mode & ~restart
             & (idle_q == IDLE_LAST);
    tick     = set_mode & ~restart & ~timeout;

    s_d     = s_q;
    cw_d    = CW;
    cw1_d   = CW1;
    idle_d  = '0;
    inc_t_d = 1'b0;
    inc_a_d = 1'b0;

    unique case (1'b1)
      btn_mode: begin
        s_d = next_mode(s_q);
        if (s_d == MODE_SET_TIME)  cw1_d = FIELD_FIRST;
        if (s_d == MODE_SET_ALARM) cw_d  = FIELD_FIRST;
      end
      timeout: begin
        s_d   = MODE_RUN;
        cw_d  = FIELD_FIRST;
        cw1_d = FIELD_FIRST;
      end
      do_next: begin
        if (s_q == MODE_SET_TIME)
          cw1_d = next_field(CW1, CW1_LAST);
        else
          cw_d = next_field(CW, CW_LAST);
      end
      do_inc: begin
        inc_t_d = (s_q == MODE_SET_TIME);
        inc_a_d = (s_q == MODE_SET_ALARM);
      end
      tick: idle_d = idle_q + 1'b1;
      default: idle_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q       <= MODE_RUN;
      CW        <= FIELD_FIRST;
      CW1       <= FIELD_FIRST;
      idle_q    <= '0;
      inc_time  <= 1'b0;
      inc_alarm <= 1'b0;
    end else begin
      s_q       <= s_d;
      CW        <= cw_d;
      CW1       <= cw1_d;
      idle_q    <= idle_d;
      inc_time  <= inc_t_d;
      inc_alarm <= inc_a_d;
    end
  end

  blink_gen #(
    .HALF (BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .blink   (BLINK)
  );

endmodule

// File: tb/tb_edit_cursor_ctrl.sv
// Bench for edit_cursor_ctrl: cycle model plus directed literals.
// Small BLINK_HALF/TIMEOUT keep the run short.
module tb_edit_cursor_ctrl;

  localparam int HALF = 4;
  localparam int TMO  = 16;
  localparam int CMAX = 3;
  localparam int C1MAX = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_next, btn_inc;
  logic [1:0] S, CW, CW1;
  logic       BLINK, inc_time, inc_alarm;

  int checks = 0;
  int errors = 0;

  edit_cursor_ctrl #(
    .CLK_HZ     (1000),
    .BLINK_HALF (HALF),
    .TIMEOUT    (TMO),
    .CW_MAX     (CMAX),
    .CW1_MAX    (C1MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_inc   (btn_inc),
    .S         (S),
    .CW        (CW),
    .CW1       (CW1),
    .BLINK     (BLINK),
    .inc_time  (inc_time),
    .inc_alarm (inc_alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input int act,
                       input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  // Model: mode/cursors as integers, blink from the
  // number of cycles since the last accepted press.
  int m_mode, m_cw, m_cw1, m_idle, m_age;
  bit m_ti, m_ta;

  task automatic model_step();
    int  nm, ncw, ncw1, nidle;
    bit  acc, set;
    nm = m_mode; ncw = m_cw; ncw1 = m_cw1;
    nidle = 0; acc = 0;
    set = (m_mode >= 2);
    m_ti = 0; m_ta = 0;
    if (rst) begin
      m_mode = 0; m_cw = 0; m_cw1 = 0;
      m_idle = 0; m_age = 0;
      return;
    end
    if (btn_mode) begin
      acc = 1;
      nm = (m_mode + 1) % 4;
      if (nm == 2) ncw1 = 0;
      if (nm == 3) ncw = 0;
    end else if (set && btn_next) begin
      acc = 1;
      if (m_mode == 2) ncw1 = (m_cw1 + 1) % (C1MAX + 1);
      else             ncw  = (m_cw + 1) % (CMAX + 1);
    end else if (set && btn_inc) begin
      acc = 1;
      if (m_mode == 2) m_ti = 1;
      else             m_ta = 1;
    end else if (set && m_idle == TMO - 1) begin
      nm = 0; ncw = 0; ncw1 = 0;
    end else if (set) begin
      nidle = m_idle + 1;
    end
    m_mode = nm; m_cw = ncw; m_cw1 = ncw1;
    m_idle = nidle;
    m_age  = acc ? 0 : m_age + 1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("S", int'(S), m_mode);
      check("CW", int'(CW), m_cw);
      check("CW1", int'(CW1), m_cw1);
      check("BLINK", int'(BLINK),
            ((m_age / HALF) % 2 == 0) ? 1 : 0);
      check("inc_time", int'(inc_time), int'(m_ti));
      check("inc_alarm", int'(inc_alarm), int'(m_ta));
    end
  end

  task automatic pulse(input bit m, input bit n,
                       input bit i);
    @(negedge clk);
    btn_mode = m; btn_next = n; btn_inc = i;
    @(negedge clk);
    btn_mode = 0; btn_next = 0; btn_inc = 0;
  endtask

  task automatic modes(input int k);
    for (int j = 0; j < k; j++) pulse(1, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cw_seq[4];
    int cw1_seq[4];
    cw_seq  = '{1, 2, 3, 0};
    cw1_seq = '{1, 2, 0, 1};
    rst = 1; btn_mode = 0; btn_next = 0; btn_inc = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check("rst_S", int'(S), 0);
    check("rst_CW", int'(CW), 0);
    check("rst_CW1", int'(CW1), 0);
    check("rst_inc", int'(inc_time | inc_alarm), 0);
    repeat (3) @(negedge clk);
    check("blink_hi_c3", int'(BLINK), 1);
    @(negedge clk);
    check("blink_lo_c4", int'(BLINK), 0);
    repeat (16) @(negedge clk);
    check("idle_S", int'(S), 0);

    modes(3);
    check("S_11", int'(S), 3);
    for (int j = 0; j < 4; j++) begin
      pulse(0, 1, 0);
      check("CW_seq", int'(CW), cw_seq[j]);
    end
    modes(3);
    check("S_10", int'(S), 2);
    check("CW1_entry", int'(CW1), 0);
    for (int j = 0; j < 4; j++) begin
      pulse(0, 1, 0);
      check("CW1_seq", int'(CW1), cw1_seq[j]);
    end
    pulse(0, 1, 0);
    check("CW1_2", int'(CW1), 2);
    pulse(0, 0, 1);
    check("inc_time_hi", int'(inc_time), 1);
    check("inc_time_cw1", int'(CW1), 2);
    check("inc_alarm_lo", int'(inc_alarm), 0);
    @(negedge clk);
    check("inc_time_1cyc", int'(inc_time), 0);

    modes(2);
    check("S_00", int'(S), 0);
    pulse(0, 0, 1);
    check("run_inc_none",
          int'(inc_time | inc_alarm), 0);

    modes(3);
    check("S_11_blink", int'(S), 3);
    check("blink_restart", int'(BLINK), 1);
    repeat (4) @(negedge clk);
    check("blink_low", int'(BLINK), 0);
    @(negedge clk);
    pulse(0, 1, 0);
    check("blink_forced", int'(BLINK), 1);
    repeat (3) @(negedge clk);
    check("blink_held", int'(BLINK), 1);
    @(negedge clk);
    check("blink_drop", int'(BLINK), 0);

    modes(3);
    check("S_10_tmo", int'(S), 2);
    repeat (15) @(negedge clk);
    check("tmo_pre", int'(S), 2);
    @(negedge clk);
    check("tmo_hit", int'(S), 0);
    check("tmo_cw1", int'(CW1), 0);

    modes(2);
    repeat (14) @(negedge clk);
    pulse(0, 1, 0);
    check("tmo_cancel_S", int'(S), 2);
    check("tmo_cancel_CW1", int'(CW1), 1);
    repeat (15) @(negedge clk);
    check("tmo2_pre", int'(S), 2);
    @(negedge clk);
    check("tmo2_hit", int'(S), 0);

    modes(2);
    pulse(1, 0, 1);
    check("prio_S", int'(S), 3);
    check("prio_CW", int'(CW), 0);
    check("prio_inc", int'(inc_time), 0);
    pulse(0, 1, 0);
    pulse(0, 1, 0);
    check("pre_rst_CW", int'(CW), 2);
    @(negedge clk);
    rst = 1; btn_inc = 1;
    @(negedge clk);
    rst = 0; btn_inc = 0;
    check("mid_rst_S", int'(S), 0);
    check("mid_rst_CW", int'(CW), 0);
    check("mid_rst_strobe", int'(inc_alarm), 0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
